// File: rtl/err_detect_stage.sv
// err_detect_stage
//   Error-detecting datapath register placed just upstream of the clock-generation
//   logic. A capture request latches d_in into q. The same input is sampled again
//   at the end of a TD-cycle detection window (shadow sample). The result is
//   reported on a dual-rail, return-to-zero pair that is handshaken with err_ack.
//   On a mismatch, q is corrected with the shadow value.
//
// Ports
//   clk      in   clock, all state updates on the rising edge
//   rst      in   asynchronous active-high reset
//   cap      in   capture request, sampled only in IDLE
//   d_in     in   [W-1:0] datapath input
//   q        out  [W-1:0] registered / corrected data
//   err1     out  error rail (shadow differed from main sample)
//   err0     out  no-error rail (shadow matched main sample)
//   err_ack  in   4-phase acknowledge for err1/err0
//   busy     out  high whenever the FSM is not idle
//   err_cnt  out  [CNTW-1:0] saturating count of detected errors
//   overrun  out  sticky: cap seen high outside IDLE

module err_detect_stage #(
    parameter int unsigned W    = 8,
    parameter int unsigned TD   = 3,
    parameter int unsigned CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cap,
    input  logic [W-1:0]    d_in,
    output logic [W-1:0]    q,
    output logic            err1,
    output logic            err0,
    input  logic            err_ack,
    output logic            busy,
    output logic [CNTW-1:0] err_cnt,
    output logic            overrun
);

    // Window counter only needs to reach TD-1; keep at least one bit for TD=1.
    localparam int unsigned WCW = (TD > 1) ? $clog2(TD) : 1;
    localparam logic [WCW-1:0] WC_LAST = WCW'(TD - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWindow,
        StReport,
        StRtz
    } state_t;

    state_t         state;
    logic [WCW-1:0] wc;

    assign busy = (state != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            q       <= '0;
            err1    <= 1'b0;
            err0    <= 1'b0;
            err_cnt <= '0;
            overrun <= 1'b0;
            wc      <= '0;
        end else begin
            // A request while busy is flagged and otherwise dropped.
            if (cap && (state != StIdle)) begin
                overrun <= 1'b1;
            end

            case (state)
                StIdle: begin
                    if (cap) begin
                        q     <= d_in;
                        wc    <= '0;
                        state <= StWindow;
                    end
                end

                StWindow: begin
                    wc <= wc + 1'b1;
                    if (wc == WC_LAST) begin
                        // Shadow compare: late data wins on a mismatch.
                        if (d_in != q) begin
                            q    <= d_in;
                            err1 <= 1'b1;
                            if (err_cnt != {CNTW{1'b1}}) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                        end else begin
                            err0 <= 1'b1;
                        end
                        state <= StReport;
                    end
                end

                // Rails are only cleared here, so an ack already high on the edge
                // that leaves WINDOW still leaves the rail up for a full cycle.
                StReport: begin
                    if (err_ack) begin
                        err1  <= 1'b0;
                        err0  <= 1'b0;
                        state <= StRtz;
                    end
                end

                StRtz: begin
                    if (!err_ack) begin
                        state <= StIdle;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
